// File: rtl/timer_master.sv
// timer_master: sequences 64-bit mtime/mtimecmp accesses over a
// 32-bit timer port with torn-read retry and glitch-free writes.
module timer_master #(
    parameter int MAX_RETRY = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_op,
    input  logic [63:0] req_wdata,
    output logic        rsp_valid,
    output logic [63:0] rsp_rdata,
    output logic        rsp_err,
    output logic [1:0]  io_addr_3_2,
    output logic        io_we,
    output logic [31:0] io_wdata,
    input  logic [31:0] io_rdata
);

    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [RW-1:0] RETRY_LIM = RW'(MAX_RETRY);

    typedef enum logic [2:0] {
        IDLE,
        RD_HI1,
        RD_LO,
        RD_HI2,
        WR0,
        WR1,
        WR2,
        DONE
    } state_t;

    state_t          state;
    state_t          state_nx;
    logic            is_cmp;
    logic [63:0]     wdata_q;
    logic [RW-1:0]   retry_cnt;
    logic [31:0]     hi1;
    logic [31:0]     lo;
    logic [31:0]     hi2;
    logic [63:0]     rdata_q;
    logic            err_q;
    logic            accept;
    logic            hi_match;
    logic            retry_out;

    // the second high-word sample is taken straight off the port
    assign hi2       = io_rdata;
    assign accept    = req_valid && (state == IDLE);
    assign hi_match  = (hi2 == hi1);
    assign retry_out = (retry_cnt == RETRY_LIM);

    // next-state decode
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (accept) state_nx = req_op[1] ? WR0 : RD_HI1;
            RD_HI1:  state_nx = RD_LO;
            RD_LO:   state_nx = RD_HI2;
            RD_HI2:  state_nx = (hi_match || retry_out) ? DONE : RD_LO;
            WR0:     state_nx = WR1;
            WR1:     state_nx = WR2;
            WR2:     state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // state register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    // request latch, read samples, retry count and response
    always_ff @(posedge clk) begin
        if (reset) begin
            is_cmp    <= 1'b0;
            wdata_q   <= '0;
            retry_cnt <= '0;
            hi1       <= '0;
            lo        <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            if (accept) begin
                is_cmp    <= req_op[0];
                wdata_q   <= req_wdata;
                retry_cnt <= '0;
            end
            unique case (state)
                RD_HI1: hi1 <= io_rdata;
                RD_LO:  lo  <= io_rdata;
                RD_HI2: begin
                    if (hi_match) begin
                        rdata_q <= {hi2, lo};
                        err_q   <= 1'b0;
                    end else if (retry_out) begin
                        rdata_q <= '0;
                        err_q   <= 1'b1;
                    end else begin
                        hi1       <= hi2;
                        retry_cnt <= retry_cnt + RW'(1);
                    end
                end
                WR2: begin
                    rdata_q <= '0;
                    err_q   <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // timer port drive; WR0 parks the low word so no carry or
    // compare match can appear while the halves are inconsistent
    always_comb begin
        io_addr_3_2 = 2'b00;
        io_we       = 1'b0;
        io_wdata    = '0;
        unique case (state)
            RD_HI1, RD_HI2: io_addr_3_2 = {is_cmp, 1'b1};
            RD_LO:          io_addr_3_2 = {is_cmp, 1'b0};
            WR0: begin
                io_addr_3_2 = {is_cmp, 1'b0};
                io_we       = 1'b1;
                io_wdata    = is_cmp ? 32'hFFFF_FFFF : 32'h0;
            end
            WR1: begin
                io_addr_3_2 = {is_cmp, 1'b1};
                io_we       = 1'b1;
                io_wdata    = wdata_q[63:32];
            end
            WR2: begin
                io_addr_3_2 = {is_cmp, 1'b0};
                io_we       = 1'b1;
                io_wdata    = wdata_q[31:0];
            end
            default: ;
        endcase
    end

    assign req_ready = (state == IDLE);
    assign rsp_valid = (state == DONE);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

endmodule

// File: tb/tb_timer_master.sv
// tb_timer_master: bench timer model, directed vector table and
// randomized requests against an arithmetic reference model.
module tb_timer_master;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [63:0] req_wdata;
    logic        rsp_valid;
    logic [63:0] rsp_rdata;
    logic        rsp_err;
    logic [1:0]  io_addr_3_2;
    logic        io_we;
    logic [31:0] io_wdata;
    logic [31:0] io_rdata;

    logic        v0;
    logic        ready0;
    logic [1:0]  op0;
    logic [63:0] wd0;
    logic        rv0;
    logic [63:0] rd0;
    logic        re0;
    logic [1:0]  addr0;
    logic        we0;
    logic [31:0] iw0;
    logic [31:0] ir0;

    logic [63:0] mtime    = 64'h0;
    logic [63:0] mtimecmp = 64'hFFFF_FFFF_FFFF_FFFF;
    logic [31:0] jcnt     = 32'h0;
    logic        ld_en    = 1'b0;
    logic [63:0] ld_val   = 64'h0;
    logic        ldc_en   = 1'b0;
    logic [63:0] ldc_val  = 64'h0;
    logic        jitter   = 1'b0;
    logic        log_en   = 1'b0;
    int          match_cnt = 0;
    logic [33:0] bus_q[$];

    int n_cmp = 0;
    int n_bad = 0;

    timer_master #(.MAX_RETRY(3)) u_dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .io_addr_3_2(io_addr_3_2),
        .io_we(io_we), .io_wdata(io_wdata), .io_rdata(io_rdata)
    );

    timer_master #(.MAX_RETRY(0)) u_dut0 (
        .clk(clk), .reset(reset),
        .req_valid(v0), .req_ready(ready0),
        .req_op(op0), .req_wdata(wd0),
        .rsp_valid(rv0), .rsp_rdata(rd0),
        .rsp_err(re0), .io_addr_3_2(addr0),
        .io_we(we0), .io_wdata(iw0), .io_rdata(ir0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // bench timer: free-running mtime, word writes, backdoor loads
    always @(posedge clk) begin
        jcnt <= jcnt + 32'd1;
        if (ld_en) mtime <= ld_val;
        else if (io_we && !io_addr_3_2[1]) begin
            if (io_addr_3_2[0]) mtime[63:32] <= io_wdata;
            else                mtime[31:0]  <= io_wdata;
        end else mtime <= mtime + 64'd1;
        if (ldc_en) mtimecmp <= ldc_val;
        else if (io_we && io_addr_3_2[1]) begin
            if (io_addr_3_2[0]) mtimecmp[63:32] <= io_wdata;
            else                mtimecmp[31:0]  <= io_wdata;
        end
    end

    // timer read mux; jitter makes the mtime high word move every cycle
    always_comb begin
        io_rdata = 32'h0;
        case (io_addr_3_2)
            2'b00: io_rdata = mtime[31:0];
            2'b01: io_rdata = jitter ? jcnt : mtime[63:32];
            2'b10: io_rdata = mtimecmp[31:0];
            2'b11: io_rdata = mtimecmp[63:32];
            default: io_rdata = 32'h0;
        endcase
    end

    assign ir0 = jcnt;

    // bus write log and compare-match monitor
    always @(negedge clk) begin
        if (log_en && io_we) bus_q.push_back({io_addr_3_2, io_wdata});
        if (log_en && (mtime >= mtimecmp)) match_cnt++;
    end

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic load_cmp(input logic [63:0] v);
        @(negedge clk);
        ldc_en  = 1'b1;
        ldc_val = v;
        @(negedge clk);
        ldc_en  = 1'b0;
    endtask

    // one request; lat counts cycles from acceptance to rsp_valid
    task automatic do_req(input logic [1:0] op, input logic [63:0] wd,
                          input logic pre, input logic [63:0] pv,
                          output int lat, output logic [63:0] rd,
                          output logic er, output logic [63:0] t0);
        int g;
        int busy;
        @(negedge clk);
        if (pre) begin
            ld_en  = 1'b1;
            ld_val = pv;
            @(negedge clk);
            ld_en  = 1'b0;
        end
        req_valid = 1'b1;
        req_op    = op;
        req_wdata = wd;
        g = 0;
        while (!req_ready && g < 20) begin
            @(negedge clk);
            g++;
        end
        chk("ready_at_accept", 64'(req_ready), 64'd1);
        t0 = mtime;
        @(negedge clk);
        req_valid = 1'b0;
        lat  = 1;
        busy = 0;
        while (!rsp_valid && lat < 40) begin
            if (req_ready) busy++;
            @(negedge clk);
            lat++;
        end
        if (req_ready) busy++;
        chk("ready_while_busy", 64'(busy), 64'd0);
        rd = rsp_rdata;
        er = rsp_err;
    endtask

    // expected read of a timer advancing one tick per cycle from t0
    function automatic void model_read(input logic [63:0] t0,
                                       input int maxr,
                                       output logic [63:0] rd,
                                       output logic er,
                                       output int lat);
        logic [63:0] v;
        logic [31:0] h1;
        logic [31:0] h2;
        logic [31:0] l;
        int t;
        v   = t0 + 64'd1;
        h1  = v[63:32];
        t   = 1;
        lat = 4;
        for (int r = 0; r <= maxr; r++) begin
            v   = t0 + 64'(t + 1);
            l   = v[31:0];
            v   = t0 + 64'(t + 2);
            h2  = v[63:32];
            lat = t + 3;
            if (h2 == h1) begin
                rd = {h2, l};
                er = 1'b0;
                return;
            end
            h1 = h2;
            t += 2;
        end
        rd = 64'h0;
        er = 1'b1;
    endfunction

    typedef struct {
        logic [1:0]  op;
        logic [63:0] wd;
        logic [63:0] pv;
        logic [63:0] exp_rd;
        logic        exp_err;
        int          exp_lat;
    } vec_t;

    vec_t vt[9];

    initial begin
        int          lat;
        logic [63:0] rd;
        logic [63:0] t0;
        logic        er;
        logic [63:0] mrd;
        logic        mer;
        int          mlat;
        logic [63:0] model_cmp;
        logic [33:0] exp_bus[3];
        int          l;

        vt[0] = '{2'd3, 64'h0BAD_F00D_CAFE_F00D, 64'h0, 64'h0, 1'b0, 4};
        vt[1] = '{2'd1, 64'h0, 64'h0, 64'h0BAD_F00D_CAFE_F00D, 1'b0, 4};
        vt[2] = '{2'd0, 64'h0, 64'h5_0000_0010, 64'h5_0000_0012, 1'b0, 4};
        vt[3] = '{2'd0, 64'h0, 64'h0_FFFF_FFFE, 64'h1_0000_0002, 1'b0, 6};
        vt[4] = '{2'd0, 64'h0, 64'h7_FFFF_FFFD, 64'h8_0000_0001, 1'b0, 6};
        vt[5] = '{2'd0, 64'h0, 64'h7_FFFF_FFFC, 64'h7_FFFF_FFFE, 1'b0, 4};
        vt[6] = '{2'd2, 64'h1, 64'h0, 64'h0, 1'b0, 4};
        vt[7] = '{2'd0, 64'h0, 64'h7_FFFF_FFFE, 64'h8_0000_0002, 1'b0, 6};
        vt[8] = '{2'd0, 64'h0, 64'hFFFF_FFFF_FFFF_FFFE, 64'h2, 1'b0, 6};

        reset     = 1'b1;
        req_valid = 1'b0;
        req_op    = 2'b00;
        req_wdata = 64'h0;
        v0        = 1'b0;
        op0       = 2'b00;
        wd0       = 64'h0;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        chk("rst_ready", 64'(req_ready), 64'd1);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_rdata", rsp_rdata, 64'h0);
        chk("rst_err", 64'(rsp_err), 64'd0);
        chk("rst_we", 64'(io_we), 64'd0);
        chk("rst_addr", 64'(io_addr_3_2), 64'd0);
        chk("rst_wdata", 64'(io_wdata), 64'd0);

        // write mtimecmp: ordered bus words, never a transient match
        load_cmp(64'hFFFF_FFFF_0000_0000);
        bus_q.delete();
        match_cnt = 0;
        log_en = 1'b1;
        do_req(2'd3, 64'h1234_5678_9ABC_DEF0, 1'b1,
               64'h1234_5678_5000_0000, lat, rd, er, t0);
        log_en = 1'b0;
        exp_bus[0] = {2'b10, 32'hFFFF_FFFF};
        exp_bus[1] = {2'b11, 32'h1234_5678};
        exp_bus[2] = {2'b10, 32'h9ABC_DEF0};
        chk("wcmp_lat", 64'(lat), 64'd4);
        chk("wcmp_nwrites", 64'(bus_q.size()), 64'd3);
        for (int i = 0; i < 3; i++) begin
            if (i < bus_q.size())
                chk($sformatf("wcmp_bus%0d", i), 64'(bus_q[i]),
                    64'(exp_bus[i]));
        end
        chk("wcmp_match", 64'(match_cnt), 64'd0);
        chk("wcmp_value", mtimecmp, 64'h1234_5678_9ABC_DEF0);

        // write mtime, then watch it count through the low-word wrap
        do_req(2'd2, 64'h2_FFFF_FFF0, 1'b0, 64'h0, lat, rd, er, t0);
        chk("wmt_lat", 64'(lat), 64'd4);
        chk("wmt_value", mtime, 64'h2_FFFF_FFF0);
        chk("wmt_rdata", rd, 64'h0);
        repeat (16) @(negedge clk);
        chk("wmt_count", mtime, 64'h3_0000_0000);

        // high word moves on every sample: retries run out
        jitter = 1'b1;
        do_req(2'd0, 64'h0, 1'b0, 64'h0, lat, rd, er, t0);
        jitter = 1'b0;
        chk("jit_lat", 64'(lat), 64'd10);
        chk("jit_err", 64'(er), 64'd1);
        chk("jit_rdata", rd, 64'h0);
        @(negedge clk);
        chk("jit_pulse", 64'(rsp_valid), 64'd0);
        chk("jit_err_hold", 64'(rsp_err), 64'd1);

        // MAX_RETRY = 0 instance fails at the first torn sample
        @(negedge clk);
        v0  = 1'b1;
        op0 = 2'b00;
        chk("r0_ready", 64'(ready0), 64'd1);
        @(negedge clk);
        v0 = 1'b0;
        chk("r0_addr", 64'(addr0), 64'd1);
        chk("r0_we", 64'({we0, iw0}), 64'd0);
        l = 1;
        while (!rv0 && l < 40) begin
            @(negedge clk);
            l++;
        end
        chk("r0_lat", 64'(l), 64'd4);
        chk("r0_err", 64'(re0), 64'd1);
        chk("r0_rdata", rd0, 64'h0);

        // vector table
        for (int i = 0; i < 9; i++) begin
            do_req(vt[i].op, vt[i].wd, 1'b1, vt[i].pv, lat, rd, er, t0);
            chk($sformatf("vec%0d_lat", i), 64'(lat), 64'(vt[i].exp_lat));
            chk($sformatf("vec%0d_rdata", i), rd, vt[i].exp_rd);
            chk($sformatf("vec%0d_err", i), 64'(er), 64'(vt[i].exp_err));
        end
        repeat (5) @(negedge clk);
        chk("rsp_hold", rsp_rdata, 64'h2);

        // reset during WR1 keeps the partial writes, drops the response
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = 2'd3;
        req_wdata = 64'hAAAA_5555_0123_4567;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        chk("rstw_we_wr1", 64'({io_we, io_addr_3_2}), 64'h7);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("rstw_ready", 64'(req_ready), 64'd1);
        chk("rstw_we", 64'(io_we), 64'd0);
        chk("rstw_valid", 64'(rsp_valid), 64'd0);
        chk("rstw_rdata", rsp_rdata, 64'h0);
        chk("rstw_partial", mtimecmp, 64'hAAAA_5555_FFFF_FFFF);
        req_valid = 1'b1;
        req_op    = 2'd1;
        @(negedge clk);
        req_valid = 1'b0;
        l = 1;
        while (!rsp_valid && l < 40) begin
            @(negedge clk);
            l++;
        end
        chk("rstw_new_lat", 64'(l), 64'd4);
        chk("rstw_new_rdata", rsp_rdata, 64'hAAAA_5555_FFFF_FFFF);

        // randomized requests against the reference model
        model_cmp = {$urandom, $urandom};
        load_cmp(model_cmp);
        for (int i = 0; i < 40; i++) begin
            logic [1:0]  op;
            logic [63:0] wd;
            logic [31:0] lo_r;
            op   = 2'($urandom_range(0, 3));
            wd   = {$urandom, $urandom};
            lo_r = ($urandom_range(0, 1) == 1)
                 ? (32'hFFFF_FFFF - 32'($urandom_range(0, 5)))
                 : $urandom;
            repeat ($urandom_range(0, 2)) @(negedge clk);
            do_req(op, wd, 1'b1, {$urandom, lo_r}, lat, rd, er, t0);
            case (op)
                2'd0: model_read(t0, 3, mrd, mer, mlat);
                2'd1: begin
                    mrd = model_cmp; mer = 1'b0; mlat = 4;
                end
                default: begin
                    mrd = 64'h0; mer = 1'b0; mlat = 4;
                end
            endcase
            chk($sformatf("rnd%0d_lat", i), 64'(lat), 64'(mlat));
            chk($sformatf("rnd%0d_rdata", i), rd, mrd);
            chk($sformatf("rnd%0d_err", i), 64'(er), 64'(mer));
            if (op == 2'd2) chk($sformatf("rnd%0d_mtime", i), mtime, wd);
            if (op == 2'd3) begin
                model_cmp = wd;
                chk($sformatf("rnd%0d_cmp", i), mtimecmp, model_cmp);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
